// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// The buffer entry layout fixes the default 32-bit PC and instruction widths.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small power-of-two FIFO of fetched {pc, instr} entries.
// Push and pop may happen together at any occupancy; flush wins over push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && !flush_i && (!full_o || do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the occupancy says empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues reads to a 1-cycle synchronous instruction
// memory and presents fetched words to decode over valid/ready.
// Optional feature macro FETCH_PERF_EN adds buffer-push and redirect counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned           BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           flush_count_o
`endif
);

    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SLOT_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic                  accept;
    logic                  redirect_taken;
    logic                  push;
    logic                  issue;
    logic [SLOT_W-1:0]     slots_used;

    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;
    logic [CNT_W-1:0]      buf_count;
    logic                  buf_full;
    logic                  buf_empty;

    assign push_entry  = '{pc: inflight_pc_q, instr: imem_rdata_i};
    assign valid_o     = !buf_empty;
    assign instr_o     = head_entry.instr;
    assign pc_o        = head_entry.pc;
    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc_q;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (accept),
        .flush_i     (redirect_taken),
        .head_o      (head_entry),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    // Handshake, redirect, squash and issue decisions plus next PC / in-flight state.
    // A slot freed by this cycle's pop counts as free so a draining stream sustains
    // one fetch per cycle; a response arriving in a redirect cycle is squashed.
    always_comb begin
        accept         = valid_o && ready_i;
        redirect_taken = accept && redirect_i;
        push           = inflight_q && !redirect_taken;
        slots_used     = SLOT_W'(buf_count) + SLOT_W'(inflight_q) - SLOT_W'(accept);
        issue          = rst_ni && !redirect_taken && !(buf_full && !accept)
                         && (slots_used < SLOT_W'(BUF_DEPTH));

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_taken) begin
            fetch_pc_d = {redirect_target_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    // PC and outstanding-request registers; reset overrides any redirect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    assign fetch_count_o = fetch_count_q;
    assign flush_count_o = flush_count_q;

    // Event counters for buffer pushes and honoured redirects; both wrap freely.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(push);
        flush_count_d = flush_count_q + 32'(redirect_taken);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A queue holds the PC decode
// must see next; every accepted instruction is popped and compared, and the next
// expected PC (sequential or redirect target) is pushed. A second instance with
// RESET_PC=FFFFFFF8 checks PC wrap-around. Honours FETCH_PERF_EN when defined.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] MAIN_RESET = 32'hBFC0_0000;
    localparam logic [31:0] WRAP_RESET = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rstN;
    logic        readyI;
    logic        redirectI;
    logic [31:0] redirectTarget;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] instrO;
    logic [31:0] pcO;
    logic        validO;

    logic        wImemReq;
    logic [31:0] wImemAddr;
    logic [31:0] wImemRdata;
    logic [31:0] wInstr;
    logic [31:0] wPc;
    logic        wValid;

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount, flushCount, wFetchCount, wFlushCount;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expQ[$];
    logic [31:0] wExp;
    int          flushModel = 0;
    logic [31:0] heldInstr;
    logic [31:0] heldPc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (MAIN_RESET)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .imem_req_o        (imemReq),
        .imem_addr_o       (imemAddr),
        .imem_rdata_i      (imemRdata),
        .instr_o           (instrO),
        .pc_o              (pcO),
        .valid_o           (validO),
        .ready_i           (readyI),
        .redirect_i        (redirectI),
        .redirect_target_i (redirectTarget)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o     (fetchCount),
        .flush_count_o     (flushCount)
`endif
    );

    fetch_stage #(
        .RESET_PC (WRAP_RESET)
    ) dutWrap (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .imem_req_o        (wImemReq),
        .imem_addr_o       (wImemAddr),
        .imem_rdata_i      (wImemRdata),
        .instr_o           (wInstr),
        .pc_o              (wPc),
        .valid_o           (wValid),
        .ready_i           (1'b1),
        .redirect_i        (1'b0),
        .redirect_target_i (32'h0)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o     (wFetchCount),
        .flush_count_o     (wFlushCount)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    // Synchronous instruction memories: read data appears the cycle after a request.
    always @(posedge clk) begin
        imemRdata  <= imemReq  ? memWord(imemAddr)  : 32'h0;
        wImemRdata <= wImemReq ? memWord(wImemAddr) : 32'h0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then run the scoreboards.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
        logic [31:0] e;
        @(negedge clk);
        rstN           = rst;
        readyI         = rdy;
        redirectI      = redir;
        redirectTarget = tgt;
        #1;
        if (!rstN) begin
            expQ.delete();
            expQ.push_back(MAIN_RESET);
            flushModel = 0;
            wExp       = WRAP_RESET;
        end else begin
            if (validO && readyI) begin
                if (expQ.size() != 1) begin
                    checkOutput("sb_depth", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pc", pcO, e);
                    checkOutput("instr", instrO, memWord(e));
                    if (redirectI) begin
                        expQ.push_back({tgt[31:2], 2'b00});
                        flushModel++;
                    end else begin
                        expQ.push_back(e + 32'd4);
                    end
                end
            end
            if (wValid) begin
                checkOutput("wrap_pc", wPc, wExp);
                wExp = wExp + 32'd4;
            end
        end
    endtask

    // Directed scenario sequence; every phase is a fixed number of cycles.
    initial begin
        rstN = 1'b0; readyI = 1'b1; redirectI = 1'b0; redirectTarget = 32'h0;

        // Reset with ready high
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("rst_valid", 32'(validO), 32'd0);
            checkOutput("rst_req", 32'(imemReq), 32'd0);
        end

        // First fetch right after release, first valid two cycles later
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("first_req", 32'(imemReq), 32'd1);
        checkOutput("first_addr", imemAddr, MAIN_RESET);
        checkOutput("first_valid0", 32'(validO), 32'd0);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch_rst", fetchCount, 32'd0);
        checkOutput("perf_flush_rst", flushCount, 32'd0);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("second_addr", imemAddr, MAIN_RESET + 32'd4);
        checkOutput("first_valid1", 32'(validO), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("first_valid2", 32'(validO), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Accept BFC00008 with a taken branch back to BFC00000
        applyStimulus(1'b1, 1'b1, 1'b1, MAIN_RESET);
        checkOutput("redir_head", pcO, MAIN_RESET + 32'd8);
        checkOutput("redir_req", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("redir_r1_valid", 32'(validO), 32'd0);
        checkOutput("redir_r1_req", 32'(imemReq), 32'd1);
        checkOutput("redir_r1_addr", imemAddr, MAIN_RESET);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_r2_valid", 32'(validO), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
        checkOutput("redir_r3_valid", 32'(validO), 32'd1);
        checkOutput("redir_r3_pc", pcO, MAIN_RESET);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Decode stall: buffer fills, no further requests, head held stable
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        heldInstr = instrO;
        heldPc    = pcO;
        checkOutput("stall_req0", 32'(imemReq), 32'd0);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_req", 32'(imemReq), 32'd0);
            checkOutput("stall_valid", 32'(validO), 32'd1);
            checkOutput("stall_instr", instrO, heldInstr);
            checkOutput("stall_pc", pcO, heldPc);
        end
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Unaligned target is forced to a word boundary
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0106);
        checkOutput("align_req0", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("align_addr", imemAddr, 32'h0000_0104);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
        checkOutput("perf_flush", flushCount, 32'(flushModel));
`endif

        // Reset coinciding with an honoured-looking redirect
        checkOutput("pre_rst_valid", 32'(validO), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_redir_addr", imemAddr, MAIN_RESET);
        checkOutput("rst_redir_req", 32'(imemReq), 32'd1);
`ifdef FETCH_PERF_EN
        checkOutput("perf_flush_rst2", flushCount, 32'd0);
`endif
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
